bus_demux: RTL and testbench
============================

BUS_DEMUX -- requirements
Module: bus_demux

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of all data ports.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the ACCESS-state cycle count after which an unanswered access aborts.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 req_valid  input  1  SHALL flag a CPU-side request.
REQ-006 req_we  input  1  SHALL mark the request as a write (1) or read (0).
REQ-007 req_addr  input  32  SHALL carry the byte address.
REQ-008 req_wdata  input  WIDTH  SHALL carry the write data.
REQ-009 req_ready  output  1  SHALL indicate that a request is accepted this cycle.
REQ-010 dev_sel  output  4  SHALL be the one-hot device select.
REQ-011 dev_we, dev_addr[13:0], dev_wdata[WIDTH-1:0]  outputs  SHALL be the registered access broadcast to all devices.
REQ-012 dev_ready  input  4  SHALL carry the per-device completion strobe.
REQ-013 dev_rdata  input  4*WIDTH  SHALL carry the device read data; device i occupies bits [i*WIDTH +: WIDTH].
REQ-014 resp_valid, resp_err (1 bit each) and resp_rdata (WIDTH)  outputs  SHALL carry the CPU-side response.

Function
REQ-015 Address decode: mapped iff req_addr[31:14]==0; device index = req_addr[13:12]; otherwise unmapped.
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP; req_ready SHALL equal 1 only in IDLE.
REQ-017 IDLE, req_valid and mapped: latch we/addr[13:0]/wdata/index; next cycle dev_sel is one-hot for that index; go to ACCESS; clear the timeout counter.
REQ-018 IDLE, req_valid and unmapped: no dev_sel; go to RESP with resp_err=1 and resp_rdata=0.
REQ-019 ACCESS: dev_sel, dev_we, dev_addr and dev_wdata SHALL hold stable; the counter SHALL increment each cycle while dev_ready[index]==0.
REQ-020 ACCESS with dev_ready[index]==1: capture the selected rdata (reads; 0 for writes); resp_err=0; go to RESP.
REQ-021 ACCESS with counter==TIMEOUT-1 and no ready: go to RESP with resp_err=1 and resp_rdata=0.
REQ-022 Ready and timeout in the same cycle: ready SHALL win (resp_err=0).
REQ-023 dev_ready bits of non-selected devices SHALL be ignored.
REQ-024 RESP: resp_valid=1 for exactly one cycle, dev_sel=0, then go to IDLE; resp_rdata and resp_err SHALL hold until the next RESP.
REQ-025 Minimum latency, from acceptance edge to resp_valid: 2 cycles for a mapped access whose device is ready in its first ACCESS cycle; 1 cycle for an unmapped access.
REQ-026 Back-to-back: a new request SHALL be accepted no sooner than the IDLE cycle that follows RESP.

Reset
REQ-027 While reset=1: state=IDLE; dev_sel=0, dev_we=0, dev_addr=0, dev_wdata=0, resp_valid=0, resp_err=0, resp_rdata=0; counter=0.
REQ-028 Reset asserted mid-access SHALL abort the access immediately with no response issued; the first cycle after release is IDLE with req_ready=1.

Structure
REQ-029 The shared macro header SHALL define the state encodings, the address-map constants (region base, index bit positions) and the TIMEOUT default.
REQ-030 A combinational sub-module addr_decode SHALL produce mapped, index and the one-hot select from req_addr.
REQ-031 Read-data selection SHALL use a 4:1 selection on the latched index.

Verification
REQ-032 Read 0x0000_1004, dev_ready[1] high in first ACCESS cycle, dev_rdata slice1=0xDEADBEEF -> dev_sel=4'b0010, dev_addr=0x1004, resp_valid 2 cycles after acceptance edge, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-033 Write 0x0000_3008 data 0x12345678, dev_ready[3] after 3 cycles -> dev_we=1, dev_wdata=0x12345678 stable throughout ACCESS, resp_rdata=0, resp_err=0.
REQ-034 Read 0x0001_0000 -> no dev_sel, resp_valid the cycle after acceptance, resp_err=1, resp_rdata=0.
REQ-035 Read 0x0000_2000, dev_ready never asserted, dev_ready[0] pulsed as noise -> resp_err=1 after 15 ACCESS cycles, noise ignored.
REQ-036 dev_ready[2] rises exactly in the 15th ACCESS cycle -> resp_err=0, data captured.
REQ-037 Reset pulsed during ACCESS -> all outputs 0 asynchronously, no resp_valid, req_ready=1 after release; a following request completes normally.

Source files
------------

// File: rtl/bus_demux_pkg.sv
// Shared definitions for the bus demultiplexer: FSM encodings, the
// address-map layout and the default access timeout.
package bus_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Device region is the bottom 16 KiB: req_addr[31:14] must be zero.
    localparam int REGION_LSB      = 14;
    // Device index comes from req_addr[13:12] (four 4 KiB windows).
    localparam int IDX_LSB         = 12;
    localparam int IDX_MSB         = 13;
    localparam int DEV_ADDR_W      = 14;
    localparam int NUM_DEV         = 4;
    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/addr_decode.sv
// Combinational address decoder: mapped flag, device index and the
// matching one-hot device select.
module addr_decode
    import bus_demux_pkg::*;
(
    input  logic [31:IDX_LSB] addr_hi,
    output logic              mapped,
    output logic [1:0]        index,
    output logic [3:0]        onehot
);

    assign mapped = (addr_hi[31:REGION_LSB] == '0);
    assign index  = addr_hi[IDX_MSB:IDX_LSB];
    assign onehot = 4'b0001 << index;

endmodule

// File: rtl/bus_demux.sv
// CPU-to-device bus demultiplexer. One outstanding access at a time:
// a request is decoded in IDLE, broadcast to the devices in ACCESS until
// the selected device answers or the timeout expires, and the result is
// presented for a single cycle in RESP.
module bus_demux
    import bus_demux_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [WIDTH-1:0]        req_wdata,
    output logic                    req_ready,
    output logic [3:0]              dev_sel,
    output logic                    dev_we,
    output logic [DEV_ADDR_W-1:0]   dev_addr,
    output logic [WIDTH-1:0]        dev_wdata,
    input  logic [3:0]              dev_ready,
    input  logic [4*WIDTH-1:0]      dev_rdata,
    output logic                    resp_valid,
    output logic                    resp_err,
    output logic [WIDTH-1:0]        resp_rdata
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state, state_nxt;
    logic               mapped;
    logic [1:0]         dec_index;
    logic [3:0]         dec_onehot;
    logic [1:0]         idx_q;
    logic [3:0]         sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sel_ready;
    logic               timeout_hit;
    logic [WIDTH-1:0]   rdata_sel;

    addr_decode u_decode (
        .addr_hi (req_addr[31:IDX_LSB]),
        .mapped  (mapped),
        .index   (dec_index),
        .onehot  (dec_onehot)
    );

    // Only the selected device's strobe counts; the others are ignored.
    assign sel_ready   = dev_ready[idx_q];
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign dev_sel    = (state == ST_ACCESS) ? sel_q : 4'b0000;

    // 4:1 read-data selection on the latched device index.
    always_comb begin
        rdata_sel = '0;
        case (idx_q)
            2'd0:    rdata_sel = dev_rdata[0*WIDTH +: WIDTH];
            2'd1:    rdata_sel = dev_rdata[1*WIDTH +: WIDTH];
            2'd2:    rdata_sel = dev_rdata[2*WIDTH +: WIDTH];
            default: rdata_sel = dev_rdata[3*WIDTH +: WIDTH];
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; ready takes priority over timeout in ACCESS.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid) state_nxt = mapped ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (sel_ready || timeout_hit) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Access latch, timeout counter and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dev_we     <= 1'b0;
            dev_addr   <= '0;
            dev_wdata  <= '0;
            idx_q      <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (mapped) begin
                            dev_we    <= req_we;
                            dev_addr  <= req_addr[DEV_ADDR_W-1:0];
                            dev_wdata <= req_wdata;
                            idx_q     <= dec_index;
                            sel_q     <= dec_onehot;
                            cnt_q     <= '0;
                        end else begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        resp_err   <= 1'b0;
                        resp_rdata <= dev_we ? '0 : rdata_sel;
                    end else if (timeout_hit) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_demux.sv
// Self-checking bench for bus_demux: a scoreboard of expected responses,
// a simple device model with configurable answer delay and noise.
module tb_bus_demux;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_we;
    logic [31:0]    req_addr;
    logic [W-1:0]   req_wdata;
    logic           req_ready;
    logic [3:0]     dev_sel;
    logic           dev_we;
    logic [13:0]    dev_addr;
    logic [W-1:0]   dev_wdata;
    logic [3:0]     dev_ready;
    logic [4*W-1:0] dev_rdata;
    logic           resp_valid;
    logic           resp_err;
    logic [W-1:0]   resp_rdata;

    typedef struct {
        logic         err;
        logic [W-1:0] rdata;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // device model controls
    int       tgt   = 0;
    int       dly   = 0;   // ACCESS cycle in which the target answers, 0 = never
    logic [3:0] noise = 4'b0000;

    bus_demux #(.WIDTH(W), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .dev_sel    (dev_sel),
        .dev_we     (dev_we),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_ready  (dev_ready),
        .dev_rdata  (dev_rdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    // Device model: counts busy cycles and strobes the target device.
    initial begin : device_model
        int acc;
        acc       = 0;
        dev_ready = 4'b0000;
        forever begin
            @(negedge clk);
            if (!reset && !req_ready && !resp_valid) acc++;
            else acc = 0;
            dev_ready = 4'b0000;
            if (dly > 0 && acc == dly) dev_ready[tgt] = 1'b1;
            if (acc[0]) dev_ready = dev_ready | noise;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [W-1:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Waits for resp_valid; returns latency and the first-cycle bus snapshot.
    task automatic wait_resp(input int limit, output int lat, output bit to,
                             output logic [3:0] sel1, output logic [13:0] addr1,
                             output logic we1);
        lat = 0; to = 1'b1; sel1 = 'x; addr1 = 'x; we1 = 'x;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (i == 1) begin sel1 = dev_sel; addr1 = dev_addr; we1 = dev_we; end
            if (resp_valid) begin lat = i; to = 1'b0; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dev_sel, dev_we, dev_addr, dev_wdata, resp_valid, resp_err, resp_rdata} !== '0)
            $display("FAIL reset_outputs: sel=%b we=%b addr=%h wd=%h rv=%b err=%b rd=%h, required all zero",
                     dev_sel, dev_we, dev_addr, dev_wdata, resp_valid, resp_err, resp_rdata);
        else n_pass++;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", req_ready);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_read;
        int lat; bit to; logic [3:0] s1; logic [13:0] a1; logic w1; exp_t e;
        tgt = 1; dly = 1; noise = 4'b0000;
        sb.push_back('{1'b0, 32'hDEADBEEF, 2});
        send(1'b0, 32'h0000_1004, '0);
        wait_resp(40, lat, to, s1, a1, w1);
        e = sb.pop_front();
        n_checks++;
        if (to) $display("FAIL read_timeout: no resp_valid within 40 cycles, required a response");
        else n_pass++;
        n_checks++;
        if (s1 !== 4'b0010) $display("FAIL read_sel: got %b required 0010", s1); else n_pass++;
        n_checks++;
        if (a1 !== 14'h1004 || w1 !== 1'b0) $display("FAIL read_addr: got addr=%h we=%b required 1004/0", a1, w1);
        else n_pass++;
        n_checks++;
        if (lat !== e.lat) $display("FAIL read_latency: got %0d required %0d", lat, e.lat); else n_pass++;
        n_checks++;
        if (resp_err !== e.err || resp_rdata !== e.rdata)
            $display("FAIL read_resp: got err=%b rd=%h required err=%b rd=%h", resp_err, resp_rdata, e.err, e.rdata);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== e.rdata)
            $display("FAIL read_hold: got rv=%b rr=%b rd=%h required rv=0 rr=1 rd=%h", resp_valid, req_ready, resp_rdata, e.rdata);
        else n_pass++;
    endtask

    task automatic test_timeout;
        int lat; bit to; logic [3:0] s1; logic [13:0] a1; logic w1; exp_t e;
        tgt = 2; dly = 0; noise = 4'b0001;
        sb.push_back('{1'b1, 32'h0, 16});
        send(1'b0, 32'h0000_2000, '0);
        wait_resp(40, lat, to, s1, a1, w1);
        e = sb.pop_front();
        n_checks++;
        if (s1 !== 4'b0100) $display("FAIL timeout_sel: got %b required 0100", s1); else n_pass++;
        n_checks++;
        if (to || lat !== e.lat) $display("FAIL timeout_latency: got %0d (expired=%0d) required %0d", lat, to, e.lat);
        else n_pass++;
        n_checks++;
        if (resp_err !== e.err || resp_rdata !== e.rdata)
            $display("FAIL timeout_resp: got err=%b rd=%h required err=%b rd=%h", resp_err, resp_rdata, e.err, e.rdata);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b1) $display("FAIL timeout_hold: got rv=%b err=%b required rv=0 err=1", resp_valid, resp_err);
        else n_pass++;
        noise = 4'b0000;
    endtask

    task automatic test_ready_at_timeout;
        int lat; bit to; logic [3:0] s1; logic [13:0] a1; logic w1; exp_t e;
        tgt = 2; dly = 15; noise = 4'b1001;
        sb.push_back('{1'b0, 32'hCAFEF00D, 16});
        send(1'b0, 32'h0000_2010, '0);
        wait_resp(40, lat, to, s1, a1, w1);
        e = sb.pop_front();
        n_checks++;
        if (to || lat !== e.lat) $display("FAIL boundary_latency: got %0d (expired=%0d) required %0d", lat, to, e.lat);
        else n_pass++;
        n_checks++;
        if (resp_err !== e.err || resp_rdata !== e.rdata)
            $display("FAIL boundary_resp: got err=%b rd=%h required err=%b rd=%h", resp_err, resp_rdata, e.err, e.rdata);
        else n_pass++;
        noise = 4'b0000;
    endtask

    task automatic test_unmapped;
        int lat; bit to; logic [3:0] s1; logic [13:0] a1; logic w1; exp_t e;
        sb.push_back('{1'b1, 32'h0, 1});
        send(1'b0, 32'h0001_0000, '0);
        wait_resp(10, lat, to, s1, a1, w1);
        e = sb.pop_front();
        n_checks++;
        if (s1 !== 4'b0000) $display("FAIL unmapped_sel: got %b required 0000", s1); else n_pass++;
        n_checks++;
        if (to || lat !== e.lat) $display("FAIL unmapped_latency: got %0d (expired=%0d) required %0d", lat, to, e.lat);
        else n_pass++;
        n_checks++;
        if (resp_err !== e.err || resp_rdata !== e.rdata)
            $display("FAIL unmapped_resp: got err=%b rd=%h required err=%b rd=%h", resp_err, resp_rdata, e.err, e.rdata);
        else n_pass++;
    endtask

    task automatic test_write;
        int lat; exp_t e;
        tgt = 3; dly = 3; noise = 4'b0000;
        sb.push_back('{1'b0, 32'h0, 4});
        send(1'b1, 32'h0000_3008, 32'h12345678);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (resp_valid) begin lat = i; break; end
            n_checks++;
            if ({dev_sel, dev_we, dev_addr, dev_wdata} !== {4'b1000, 1'b1, 14'h3008, 32'h12345678})
                $display("FAIL write_stable_c%0d: got sel=%b we=%b addr=%h wd=%h required 1000/1/3008/12345678",
                         i, dev_sel, dev_we, dev_addr, dev_wdata);
            else n_pass++;
        end
        e = sb.pop_front();
        n_checks++;
        if (lat !== e.lat) $display("FAIL write_latency: got %0d required %0d", lat, e.lat); else n_pass++;
        n_checks++;
        if (resp_err !== e.err || resp_rdata !== e.rdata || dev_sel !== 4'b0000)
            $display("FAIL write_resp: got err=%b rd=%h sel=%b required err=%b rd=%h sel=0000",
                     resp_err, resp_rdata, dev_sel, e.err, e.rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic exp_rv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        sb.push_back('{1'b1, 32'h0, 1});
        sb.push_back('{1'b1, 32'h0, 1});
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0004_0000; req_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) req_valid = 1'b0;
            n_checks++;
            if (resp_valid !== exp_rv[i] || req_ready !== ~exp_rv[i])
                $display("FAIL b2b_c%0d: got rv=%b rr=%b required rv=%b rr=%b", i, resp_valid, req_ready, exp_rv[i], ~exp_rv[i]);
            else n_pass++;
            if (resp_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (resp_err !== e.err || resp_rdata !== e.rdata)
                    $display("FAIL b2b_resp%0d: got err=%b rd=%h required err=%b rd=%h", i, resp_err, resp_rdata, e.err, e.rdata);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_access;
        int lat; bit to; logic [3:0] s1; logic [13:0] a1; logic w1; exp_t e;
        tgt = 1; dly = 0; noise = 4'b0000;
        send(1'b0, 32'h0000_1010, '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({dev_sel, dev_we, dev_addr, dev_wdata, resp_valid, resp_err, resp_rdata} !== '0)
            $display("FAIL midreset_outputs: sel=%b we=%b addr=%h wd=%h rv=%b err=%b rd=%h, required all zero",
                     dev_sel, dev_we, dev_addr, dev_wdata, resp_valid, resp_err, resp_rdata);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1)
                $display("FAIL midreset_idle_c%0d: got rv=%b rr=%b required rv=0 rr=1", i, resp_valid, req_ready);
            else n_pass++;
        end
        dly = 2;
        sb.push_back('{1'b0, 32'hDEADBEEF, 3});
        send(1'b0, 32'h0000_1010, '0);
        wait_resp(40, lat, to, s1, a1, w1);
        e = sb.pop_front();
        n_checks++;
        if (to || lat !== e.lat || resp_err !== e.err || resp_rdata !== e.rdata)
            $display("FAIL midreset_after: got lat=%0d err=%b rd=%h required lat=%0d err=%b rd=%h",
                     lat, resp_err, resp_rdata, e.lat, e.err, e.rdata);
        else n_pass++;
    endtask

    initial begin
        dev_rdata = {32'h3333_3333, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0BAD_0000};
        test_reset();
        test_read();
        test_timeout();
        test_ready_at_timeout();
        test_unmapped();
        test_write();
        test_back_to_back();
        test_reset_mid_access();
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
